// File: rtl/fp_handshake_pkg.sv
// fp_handshake_pkg: shared state type and constants for the float operator handshake
package fp_handshake_pkg;
  localparam int FP_WIDTH = 32;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_Z} fp_state_e;
endpackage

// File: rtl/fp_operand_issuer.sv
// fp_operand_issuer: stages an operand pair, drives it into a strobe/ack float operator, returns z or an abort NaN
module fp_operand_issuer
  import fp_handshake_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_a_stb,
  output logic             op_b_stb,
  input  logic             op_a_ack,
  input  logic             op_b_ack,
  input  logic [WIDTH-1:0] op_z,
  input  logic             op_z_stb,
  output logic             op_z_ack,
  output logic             op_rst,
  output logic [WIDTH-1:0] res,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready
);
  localparam int WDW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_INC = WDW'(TIMEOUT_CYCLES != 0);
  fp_state_e state_q, state_d;
  logic stg_full_q, stg_full_d;
  logic [WIDTH-1:0] stg_a_q, stg_a_d, stg_b_q, stg_b_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic a_stb_q, a_stb_d, b_stb_q, b_stb_d, op_rst_q, op_rst_d;
  logic res_err_q, res_err_d, res_valid_q, res_valid_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic out_free, expire, z_ack;
  // next-state: staging load, operand issue, z collection and watchdog abort
  always_comb begin
    out_free = !res_valid_q || res_ready;
    expire = TIMEOUT_CYCLES != 0 && state_q != ST_IDLE && wd_q == WD_MAX;
    z_ack = state_q == ST_WAIT_Z && !expire && out_free;
    state_d = state_q;
    stg_full_d = stg_full_q;
    stg_a_d = stg_a_q;
    stg_b_d = stg_b_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    a_stb_d = a_stb_q;
    b_stb_d = b_stb_q;
    wd_d = wd_q;
    op_rst_d = 1'b0;
    res_d = res_q;
    res_err_d = res_err_q;
    res_valid_d = res_valid_q && !res_ready;
    if (in_valid && !stg_full_q) begin
      stg_full_d = 1'b1;
      stg_a_d = in_a;
      stg_b_d = in_b;
    end
    if (expire) begin
      a_stb_d = 1'b0;
      b_stb_d = 1'b0;
      state_d = out_free ? ST_IDLE : ST_WAIT_Z;
      op_rst_d = out_free;
      res_d = out_free ? WIDTH'(FP_QNAN) : res_q;
      res_err_d = out_free || res_err_q;
      res_valid_d = out_free || res_valid_d;
    end else if (state_q == ST_IDLE && stg_full_q) begin
      state_d = ST_SEND;
      stg_full_d = 1'b0;
      op_a_d = stg_a_q;
      op_b_d = stg_b_q;
      a_stb_d = 1'b1;
      b_stb_d = 1'b1;
      wd_d = '0;
    end else if (state_q == ST_SEND) begin
      a_stb_d = a_stb_q && !op_a_ack;
      b_stb_d = b_stb_q && !op_b_ack;
      state_d = !a_stb_d && !b_stb_d ? ST_WAIT_Z : ST_SEND;
      wd_d = !a_stb_d && !b_stb_d ? '0 : wd_q + WD_INC;
    end else if (state_q == ST_WAIT_Z) begin
      if (op_z_stb && z_ack) begin
        res_d = op_z;
        res_err_d = 1'b0;
        res_valid_d = 1'b1;
        state_d = ST_IDLE;
      end else if (!(op_z_stb && !out_free)) begin
        wd_d = wd_q + WD_INC;
      end
    end
  end
  // state registers, all cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      stg_full_q <= 1'b0;
      stg_a_q <= '0;
      stg_b_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      a_stb_q <= 1'b0;
      b_stb_q <= 1'b0;
      wd_q <= '0;
      op_rst_q <= 1'b0;
      res_q <= '0;
      res_err_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stg_full_q <= stg_full_d;
      stg_a_q <= stg_a_d;
      stg_b_q <= stg_b_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      a_stb_q <= a_stb_d;
      b_stb_q <= b_stb_d;
      wd_q <= wd_d;
      op_rst_q <= op_rst_d;
      res_q <= res_d;
      res_err_q <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end
  assign in_ready = !stg_full_q;
  assign op_a = op_a_q;
  assign op_b = op_b_q;
  assign op_a_stb = a_stb_q;
  assign op_b_stb = b_stb_q;
  assign op_z_ack = z_ack;
  assign op_rst = op_rst_q;
  assign res = res_q;
  assign res_err = res_err_q;
  assign res_valid = res_valid_q;
endmodule

// File: tb/tb_fp_operand_issuer.sv
// tb_fp_operand_issuer: scoreboard bench with a behavioural strobe/ack float operator
module tb_fp_operand_issuer;
  import fp_handshake_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic in_valid, in_ready, op_a_stb, op_b_stb, op_a_ack, op_b_ack, op_z_stb, op_z_ack;
  logic op_rst, res_err, res_valid, res_ready;
  logic [31:0] in_a, in_b, op_a, op_b, op_z, res;
  int n_chk = 0;
  int n_pass = 0;
  int n_res = 0;
  int a_dly = 0;
  int b_dly = 0;
  int z_lat = 0;
  bit z_never = 1'b0;
  bit a_fire, b_fire, z_fire, rst_hit, z_prev;
  logic [32:0] sb[$];

  always #5 CLK = ~CLK;

  fp_operand_issuer #(.WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_a(op_a), .op_b(op_b), .op_a_stb(op_a_stb), .op_b_stb(op_b_stb),
    .op_a_ack(op_a_ack), .op_b_ack(op_b_ack),
    .op_z(op_z), .op_z_stb(op_z_stb), .op_z_ack(op_z_ack), .op_rst(op_rst),
    .res(res), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] fake_op(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h404CCCCD && b == 32'h3FCCCCCD) ? 32'h4099999A : a ^ {b[15:0], b[31:16]};
  endfunction

  // sample just before each rising edge: handshakes, scoreboard pops, z-to-res latency
  initial forever begin
    @(negedge CLK);
    #4;
    if (z_prev) check("z_to_res_valid", res_valid, 1);
    if (res_valid && res_ready && !RST) begin
      n_res++;
      check("pop_expected", sb.size() > 0, 1);
      if (sb.size() > 0) check("res", {res_err, res}, sb.pop_front());
    end
    a_fire = op_a_stb && op_a_ack;
    b_fire = op_b_stb && op_b_ack;
    z_fire = op_z_stb && op_z_ack;
    rst_hit = RST;
    z_prev = z_fire && !RST;
  end

  // behavioural operator: programmable ack delays and z latency
  initial begin
    int a_cnt, b_cnt, z_cnt;
    bit got_a, got_b;
    logic [31:0] cap_a, cap_b;
    a_cnt = 0; b_cnt = 0; z_cnt = 0; got_a = 0; got_b = 0; cap_a = 0; cap_b = 0;
    op_a_ack = 0; op_b_ack = 0; op_z_stb = 0; op_z = 0;
    forever begin
      @(negedge CLK);
      if (rst_hit || op_rst) begin
        op_a_ack = 0; op_b_ack = 0; op_z_stb = 0;
        a_cnt = 0; b_cnt = 0; z_cnt = 0; got_a = 0; got_b = 0;
      end else begin
        if (a_fire) begin
          op_a_ack = 0; got_a = 1;
        end else if (op_a_stb && !op_a_ack) begin
          if (a_cnt >= a_dly) begin op_a_ack = 1; cap_a = op_a; a_cnt = 0; end
          else a_cnt++;
        end
        if (b_fire) begin
          op_b_ack = 0; got_b = 1;
        end else if (op_b_stb && !op_b_ack) begin
          if (b_cnt >= b_dly) begin op_b_ack = 1; cap_b = op_b; b_cnt = 0; end
          else b_cnt++;
        end
        if (z_fire) begin
          op_z_stb = 0; got_a = 0; got_b = 0; z_cnt = 0;
        end else if (got_a && got_b && !op_z_stb && !z_never) begin
          if (z_cnt >= z_lat) begin op_z_stb = 1; op_z = fake_op(cap_a, cap_b); end
          else z_cnt++;
        end
      end
    end
  end

  // call at a falling edge; returns at the falling edge after the accepting edge
  task automatic put(input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    in_valid = 1; in_a = a; in_b = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      #4;
      if (in_ready) begin
        ok = 1;
        sb.push_back(z_never ? {1'b1, FP_QNAN} : {1'b0, fake_op(a, b)});
      end
      @(negedge CLK);
    end
    in_valid = 0;
    check("put_accept", ok, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      #4;
      ok = sb.size() == 0 && !res_valid && in_ready && !op_a_stb && !op_b_stb && !op_z_stb;
    end
    check("drain", ok, 1);
    @(negedge CLK);
  endtask

  task automatic check_reset();
    check("rst_ctl", {in_ready, op_a_stb, op_b_stb, op_z_ack, op_rst, res_valid, res_err}, 7'b1000000);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_res", res, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok, leak, quiet;
    int n0, n;
    in_valid = 0; in_a = 0; in_b = 0; res_ready = 1;
    @(negedge CLK);
    @(negedge CLK);
    #4;
    check_reset();
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    // single op with staggered acks
    a_dly = 1; b_dly = 3; z_lat = 10;
    put(32'h404CCCCD, 32'h3FCCCCCD);
    #4;
    check("single_stb_edge0", {op_a_stb, op_b_stb}, 2'b00);
    @(negedge CLK);
    #4;
    check("single_stb_edge1", {op_a_stb, op_b_stb}, 2'b11);
    check("single_op_a", op_a, 32'h404CCCCD);
    check("single_op_b", op_b, 32'h3FCCCCCD);
    drain();
    // simultaneous acks
    a_dly = 2; b_dly = 2; z_lat = 3;
    put(32'h11112222, 32'h33334444);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      #4;
      ok = op_a_stb && op_a_ack;
    end
    check("simul_found", ok, 1);
    check("simul_both_ack", {op_b_stb, op_b_ack}, 2'b11);
    @(negedge CLK);
    #4;
    check("simul_stb_low", {op_a_stb, op_b_stb}, 2'b00);
    check("simul_wait_z", op_z_ack, 1);
    drain();
    // back-to-back
    a_dly = 0; b_dly = 0; z_lat = 1;
    put(32'hA0000001, 32'h0B000002);
    put(32'hA0000003, 32'h0B000004);
    #4;
    check("b2b_ready_low", in_ready, 0);
    n0 = n_res;
    @(negedge CLK);
    put(32'hA0000005, 32'h0B000006);
    check("b2b_third_after_first", n_res - n0, 1);
    drain();
    // backpressure on the result register
    res_ready = 0;
    put(32'hCAFE0001, 32'h00BEEF01);
    put(32'hCAFE0002, 32'h00BEEF02);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      #4;
      ok = op_z_stb && res_valid;
    end
    check("bp_reached", ok, 1);
    leak = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #4;
      leak |= op_z_ack | op_rst;
    end
    check("bp_no_zack_no_rst", leak, 0);
    check("bp_z_held", op_z_stb, 1);
    check("bp_res_hold", {res_err, res}, {1'b0, fake_op(32'hCAFE0001, 32'h00BEEF01)});
    @(negedge CLK);
    res_ready = 1;
    drain();
    // watchdog abort
    z_never = 1;
    put(32'h0DEAD000, 32'h000BAD00);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      #4;
      ok = op_a_stb && op_a_ack && op_b_stb && op_b_ack;
    end
    check("to_acks", ok, 1);
    n = 0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      #4;
      n++;
      ok = op_rst;
    end
    check("to_latency", n, 18);
    check("to_err_res", {res_valid, res_err, res}, {2'b11, FP_QNAN});
    check("to_strobes_low", {op_a_stb, op_b_stb, op_z_ack}, 3'b000);
    @(negedge CLK);
    z_never = 0;
    #4;
    check("to_rst_single", op_rst, 0);
    drain();
    put(32'h12345678, 32'h9ABCDEF0);
    drain();
    // reset with one op in WAIT_Z and one staged
    z_lat = 8;
    put(32'h55550001, 32'h66660001);
    put(32'h55550002, 32'h66660002);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      #4;
      ok = op_z_ack;
    end
    check("rst_in_wait_z", ok, 1);
    check("rst_staged", in_ready, 0);
    @(negedge CLK);
    RST = 1;
    sb.delete();
    @(negedge CLK);
    RST = 0;
    #4;
    check_reset();
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      #4;
      quiet |= res_valid | op_rst | op_a_stb | op_b_stb;
    end
    check("rst_no_result", quiet, 0);
    @(negedge CLK);
    put(32'h77770001, 32'h88880001);
    drain();
    check("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
